muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the multicycle ARM core. Executes UMULL, SMULL, UDIV and SDIV over several cycles so that no single-cycle 64-bit multiplier or divider is needed in the ALU.
- It sits beside the ALU.
- The main FSM pulses `start` when decode flags a mul/div instruction, then holds its current state while `busy` is high.
- It writes back on `done`: `result_lo` goes to Rd (RdLo for long multiplies), and `result_hi` goes to RdHi or the remainder.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 28 ++
 rtl/muldiv_seq.sv | 128 ++++++++++++
 tb/tb_muldiv_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the iterative multiply/divide sequencer
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_LAT   = MULDIV_WIDTH + 3;

  typedef enum logic [1:0] {
    OP_UMULL = 2'b00,
    OP_SMULL = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add for multiply or restoring shift-subtract for divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH:0]   acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH:0]   acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic           ge;

  // Multiply shifts the accumulator right after a conditional add; divide shifts left and keeps the trial subtraction when it does not borrow
  always_comb begin
    sum      = acc_hi_i + (acc_lo_i[0] ? {1'b0, operand_i} : '0);
    sh       = {acc_hi_i[WIDTH-1:0], acc_lo_i[WIDTH-1]};
    ge       = sh >= {1'b0, operand_i};
    diff     = sh - {1'b0, operand_i};
    acc_hi_o = div_i ? (ge ? diff : sh) : {1'b0, sum[WIDTH:1]};
    acc_lo_o = div_i ? {acc_lo_i[WIDTH-2:0], ge} : {sum[0], acc_lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: fixed-latency iterative UMULL/SMULL/UDIV/SDIV sequencer beside the ALU
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, m_q, lo_q;
  logic [WIDTH:0]     hi_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q, negr_q;
  logic [WIDTH-1:0]   res_hi_q, res_lo_q;
  logic               div0_q;

  logic               sa, sb, dz;
  logic [WIDTH-1:0]   ma, mb, q_s, r_s, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i     (op_q[1]),
    .acc_hi_i  (hi_q),
    .acc_lo_i  (lo_q),
    .operand_i (m_q),
    .acc_hi_o  (step_hi),
    .acc_lo_o  (step_lo)
  );

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next state: abort always returns to IDLE, RUN lasts until the counter expires
  always_comb begin
    state_d = abort_i             ? S_IDLE :
              state_q == S_IDLE   ? (start_i ? S_PREP : S_IDLE) :
              state_q == S_PREP   ? S_RUN :
              state_q == S_RUN    ? (cnt_q == '0 ? S_FIX : S_RUN) :
              state_q == S_FIX    ? S_DONE : S_IDLE;
  end

  // Outputs derived from state and the held result registers
  always_comb begin
    busy_o      = state_q != S_IDLE;
    done_o      = state_q == S_DONE;
    result_hi_o = res_hi_q;
    result_lo_o = res_lo_q;
    div0_o      = div0_q;
  end

  // Magnitudes and sign fixups; negating the most negative value wraps to itself, which is the right magnitude
  always_comb begin
    sa     = op_q[0] & a_q[WIDTH-1];
    sb     = op_q[0] & b_q[WIDTH-1];
    ma     = sa ? -a_q : a_q;
    mb     = sb ? -b_q : b_q;
    dz     = b_q == '0;
    prod   = {hi_q[WIDTH-1:0], lo_q};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo_q : lo_q;
    r_s    = negr_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
    fix_hi = op_q[1] ? (dz ? a_q : r_s) : prod_s[2*WIDTH-1:WIDTH];
    fix_lo = op_q[1] ? (dz ? '0 : q_s) : prod_s[WIDTH-1:0];
  end

  // Datapath: capture on accept, set up magnitudes in PREP, iterate in RUN, publish results in FIX
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_i && !abort_i) begin
        op_q <= op_i;
        a_q  <= src_a_i;
        b_q  <= src_b_i;
      end
      if (state_q == S_PREP) begin
        hi_q   <= '0;
        lo_q   <= op_q[1] ? ma : mb;
        m_q    <= op_q[1] ? mb : ma;
        neg_q  <= sa ^ sb;
        negr_q <= sa;
        cnt_q  <= CW'(WIDTH - 1);
      end
      if (state_q == S_RUN) begin
        hi_q  <= step_hi;
        lo_q  <= step_lo;
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == S_FIX && !abort_i) begin
        res_hi_q <= fix_hi;
        res_lo_q <= fix_lo;
        div0_q   <= op_q[1] & dz;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized self-checking bench against a cycle-count behavioural model
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy_o, done_o, div0_o;
  logic [31:0] result_hi_o, result_lo_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  logic        m_busy, m_done;
  int          m_k;
  logic [64:0] m_res, m_pend;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .start_i     (start),
    .op_i        (op),
    .src_a_i     (a),
    .src_b_i     (b),
    .abort_i     (abort),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_hi_o (result_hi_o),
    .result_lo_o (result_lo_o),
    .div0_o      (div0_o)
  );

  always #5 clk = ~clk;

  // Architectural result {div0, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] ref_f(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[1] && y == 32'd0) return {1'b1, x, 32'd0};
    case (o)
      2'b00:   return {1'b0, ux * uy};
      2'b01:   return {1'b0, sx * sy};
      2'b10:   return {1'b0, x % y, x / y};
      default: begin
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Behavioural model: an accepted op is busy for MULDIV_LAT cycles and shows its result with done in the last one
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
      m_res  <= '0;
      m_pend <= '0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start && !abort) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_pend <= ref_f(op, a, b);
      end
    end else if (abort || m_k == MULDIV_LAT) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == MULDIV_LAT) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk)
    if (cmp_en)
      chk("cycle", {busy_o, done_o, div0_o, result_hi_o, result_lo_o}, {m_busy, m_done, m_res[64], m_res[63:0]});

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int ab, input int sp1, input int sp2, output int nd, output int dc);
    nd = 0;
    dc = -1;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; op = o; a = x; b = y;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_o) begin
        nd++;
        if (dc < 0) dc = c;
      end
      start = (c == sp1) || (c == sp2);
      abort = (c == ab);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, dc, ab, sp;
    logic [1:0]  o;
    logic [31:0] x, y;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
    chk("model_umull", ref_f(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
    chk("model_sdiv",  ref_f(2'b11, 32'hFFFF_FF9C, 32'd7),         {1'b0, 64'hFFFF_FFFE_FFFF_FFF2});
    chk("model_ovf",   ref_f(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});
    repeat (3) @(negedge clk);
    chk("reset_state", {busy_o, done_o, div0_o, result_hi_o, result_lo_o}, 67'd0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    run(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, nd, dc);
    chk("umull_ndone", nd, 1);
    chk("umull_lat", dc, MULDIV_LAT);
    chk("umull_res", {result_hi_o, result_lo_o}, 64'hFFFF_FFFE_0000_0001);
    run(OP_SMULL, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, nd, dc);
    chk("smull_res", {result_hi_o, result_lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    run(OP_UDIV, 32'd100, 32'd7, 0, 0, 0, nd, dc);
    chk("udiv_res", {div0_o, result_hi_o, result_lo_o}, {1'b0, 32'd2, 32'd14});
    run(OP_SDIV, 32'hFFFF_FF9C, 32'd7, 0, 0, 0, nd, dc);
    chk("sdiv_res", {result_hi_o, result_lo_o}, 64'hFFFF_FFFE_FFFF_FFF2);
    run(OP_UDIV, 32'd5, 32'd0, 0, 0, 0, nd, dc);
    chk("div0_res", {div0_o, result_hi_o, result_lo_o}, {1'b1, 32'd5, 32'd0});
    chk("div0_lat", dc, MULDIV_LAT);
    run(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, nd, dc);
    chk("ovf_res", {div0_o, result_hi_o, result_lo_o}, {1'b0, 32'd0, 32'h8000_0000});
    run(OP_UMULL, 32'd3, 32'd5, 0, 5, 35, nd, dc);
    chk("spam_ndone", nd, 1);
    chk("spam_res", {result_hi_o, result_lo_o}, 64'd15);
    run(OP_UDIV, 32'd1000, 32'd3, 10, 0, 0, nd, dc);
    chk("abort_ndone", nd, 0);
    chk("abort_res", {result_hi_o, result_lo_o}, 64'd15);

    @(negedge clk);
    start = 1'b1; op = OP_UMULL; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {busy_o, done_o, div0_o, result_hi_o, result_lo_o}, 67'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run(OP_UMULL, 32'd6, 32'd7, 0, 0, 0, nd, dc);
    chk("post_reset_res", {result_hi_o, result_lo_o}, 64'd42);
    chk("post_reset_lat", dc, MULDIV_LAT);

    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = OP_UDIV; a = 32'd8; b = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", busy_o, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom_range(0, 3));
      x  = pick();
      y  = pick();
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 36) : 0;
      sp = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 35) : 0;
      run(o, x, y, ab, sp, 0, nd, dc);
      chk("rand_ndone", nd, (ab == 0 || ab >= MULDIV_LAT) ? 1 : 0);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
